// File: rtl/vdic_dut_cmd_proc.sv
// Byte-stream command processor: one command byte followed by data bytes is
// folded through the selected operation into a 16-bit result, reported with
// a one-cycle dout_valid strobe.
// Optional build macro: DIN_PARITY_EN adds din_par and odd-parity checking.
module vdic_dut_cmd_proc #(
    parameter int MAX_SIZE = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_valid,
`ifdef DIN_PARITY_EN
    input  logic       din_par,
`endif
    output logic [7:0] data1_o,
    output logic [7:0] data2_o,
    output logic       dout_valid,
    output logic       err_o
);

    localparam int CW = $clog2(MAX_SIZE + 1);

    localparam logic [7:0] CMD_NOP = 8'h00;
    localparam logic [7:0] CMD_AND = 8'h01;
    localparam logic [7:0] CMD_OR  = 8'h02;
    localparam logic [7:0] CMD_XOR = 8'h03;
    localparam logic [7:0] CMD_ADD = 8'h10;
    localparam logic [7:0] CMD_SUB = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        OUT
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [7:0]      cmd;
    logic [CW-1:0]   count;
    logic [15:0]     acc;
    logic [15:0]     acc_op;
    logic            ovf;
    logic            par_err;
    logic            byte_par_err;

    logic            capture;
    logic            accept;
    logic            load_out;
    logic            cmd_valid;
    logic            res_err;
    logic [15:0]     result;

`ifdef DIN_PARITY_EN
    assign byte_par_err = ~(^{din, din_par});
`else
    assign byte_par_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-cycle control strobes
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        accept     = 1'b0;
        load_out   = 1'b0;
        dout_valid = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid) begin
                    capture    = 1'b1;
                    state_next = ACC;
                end
            end
            ACC: begin
                if (din_valid) begin
                    accept = 1'b1;
                end else begin
                    load_out   = 1'b1;
                    state_next = OUT;
                end
            end
            OUT: begin
                dout_valid = 1'b1;
                if (din_valid) begin
                    capture    = 1'b1;
                    state_next = ACC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Fold of the current data byte into the accumulator
    always_comb begin
        acc_op = acc;
        case (cmd)
            CMD_AND: acc_op = acc & {8'h00, din};
            CMD_OR:  acc_op = acc | {8'h00, din};
            CMD_XOR: acc_op = acc ^ {8'h00, din};
            CMD_ADD: acc_op = acc + {8'h00, din};
            CMD_SUB: acc_op = acc - {8'h00, din};
            default: acc_op = acc;
        endcase
    end

    // Command validity and final result selection
    always_comb begin
        cmd_valid = 1'b0;
        case (cmd)
            CMD_NOP, CMD_AND, CMD_OR, CMD_XOR, CMD_ADD, CMD_SUB: cmd_valid = 1'b1;
            default: cmd_valid = 1'b0;
        endcase
        res_err = !cmd_valid || (count == '0) || ovf || par_err;
        if (res_err) begin
            result = '1;
        end else if (cmd == CMD_NOP) begin
            result = '0;
        end else begin
            result = acc;
        end
    end

    // Frame context: command, byte count, accumulator and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd     <= '0;
            count   <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            par_err <= 1'b0;
        end else if (capture) begin
            cmd     <= din;
            count   <= '0;
            acc     <= '0;
            ovf     <= 1'b0;
            par_err <= byte_par_err;
        end else if (accept) begin
            if (byte_par_err) begin
                par_err <= 1'b1;
            end
            if (count == CW'(MAX_SIZE)) begin
                ovf <= 1'b1;
            end else begin
                acc   <= (count == '0) ? {8'h00, din} : acc_op;
                count <= count + CW'(1);
            end
        end
    end

    // Result registers, loaded on the edge entering OUT and held until the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            data1_o <= '0;
            data2_o <= '0;
            err_o   <= 1'b0;
        end else if (load_out) begin
            data1_o <= result[15:8];
            data2_o <= result[7:0];
            err_o   <= res_err;
        end
    end

endmodule
